// File: rtl/data_mem_ws_if.sv
// Request/response bus between the core's load/store path and data_mem_ws.
// The master drives a request and holds it until ready; the slave answers
// with a one-cycle rsp_valid pulse carrying rd_data and misaligned.
interface data_mem_ws_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  wr_sel;
  logic [1:0]            size;
  logic                  unsigned_ld;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wr_data;
  logic                  ready;
  logic                  rsp_valid;
  logic [31:0]           rd_data;
  logic                  misaligned;

  modport master (
    output req, wr_sel, size, unsigned_ld, addr, wr_data,
    input  ready, rsp_valid, rd_data, misaligned
  );

  modport slave (
    input  req, wr_sel, size, unsigned_ld, addr, wr_data,
    output ready, rsp_valid, rd_data, misaligned
  );
endinterface

// File: rtl/data_mem_ws.sv
// RV32I data memory with configurable wait states. One request is accepted
// in IDLE, optionally held in WAIT, and committed (store merge or load
// extract) on the edge that enters RESP, where rsp_valid pulses for a cycle.
module data_mem_ws #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_ws_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic             uns;
    logic [IDX_W+1:0] addr;
    logic [31:0]      wdata;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_in, req_cur;
  logic [31:0] rd_data_q;
  logic        mis_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, commit, mis_cur;
  logic [IDX_W-1:0] idx_cur;
  logic [31:0]      word_rd, load_val, wrep;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [3:0]       be;

  // Address bits above the array size are deliberately ignored (wrap).
  if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_WIDTH-1:IDX_W+2];
  end

  assign req_in  = '{wr: bus.wr_sel, size: bus.size, uns: bus.unsigned_ld,
                     addr: bus.addr[IDX_W+1:0], wdata: bus.wr_data};
  assign accept  = bus.req && (state_q == ST_IDLE);
  // With zero wait states the commit edge is the accept edge, so the live
  // bus fields are used instead of the not-yet-captured copy.
  assign req_cur = (state_q == ST_IDLE) ? req_in : req_q;
  assign commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign idx_cur = req_cur.addr[IDX_W+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
               else               cnt_d   = cnt_q - 4'd1;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Alignment fault, read-lane extraction and store lane enables.
  always_comb begin
    mis_cur  = 1'b0;
    word_rd  = mem[idx_cur];
    lane_b   = word_rd[{req_cur.addr[1:0], 3'b000} +: 8];
    lane_h   = req_cur.addr[1] ? word_rd[31:16] : word_rd[15:0];
    load_val = 32'd0;
    be       = 4'b0000;
    wrep     = req_cur.wdata;
    case (req_cur.size)
      2'b00: begin
        load_val = req_cur.uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        be       = 4'b0001 << req_cur.addr[1:0];
        wrep     = {4{req_cur.wdata[7:0]}};
      end
      2'b01: begin
        mis_cur  = req_cur.addr[0];
        load_val = req_cur.uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        be       = req_cur.addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{req_cur.wdata[15:0]}};
      end
      2'b10: begin
        mis_cur  = (req_cur.addr[1:0] != 2'b00);
        load_val = word_rd;
        be       = 4'b1111;
      end
      default: mis_cur = 1'b1;
    endcase
  end

  // Control state, captured request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      req_q     <= '0;
      rd_data_q <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_in;
      if (commit) begin
        mis_q     <= mis_cur;
        rd_data_q <= (!req_cur.wr && !mis_cur) ? load_val : 32'd0;
      end
    end
  end

  // Store merge into the array on RESP entry; faulting stores are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the array is intentionally not reset; contents survive rst_n and map onto plain RAM.
    if (commit && req_cur.wr && !mis_cur) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_cur][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rd_data    = rd_data_q;
  assign bus.misaligned = mis_q;
endmodule
